add4_seq_ctrl: RTL and testbench

Sequencing controller that builds a 4-bit add with carry-out from one 2-bit adder slice over successive clock cycles. The slice has no carry-in. The block sits directly upstream of the slice: it drives its A/B operand pins and samples its S/Carry outputs. It also sits downstream of the operand source, accepting 4-bit operand pairs via valid/ready and returning a 4-bit sum plus carry via valid/ready.

---
 rtl/add4_seq_pkg.sv | 16 +
 rtl/add4_seq_ctrl_if.sv | 28 ++
 rtl/add4_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_add4_seq_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/add4_seq_pkg.sv
// rtl/add4_seq_pkg.sv - shared types and constants for the sequenced 4-bit adder controller
package add4_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        FIX,
        DONE
    } state_t;

    localparam int          HALF_W     = 2;
    localparam int          FULL_W     = 4;
    localparam logic [1:0]  FIX_ADDEND = 2'b01;

endpackage

// File: rtl/add4_seq_ctrl_if.sv
// rtl/add4_seq_ctrl_if.sv - operand/result handshakes and 2-bit slice pins of the controller
interface add4_seq_ctrl_if;
    import add4_seq_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [FULL_W-1:0] in_a;
    logic [FULL_W-1:0] in_b;
    logic [HALF_W-1:0] add_a;
    logic [HALF_W-1:0] add_b;
    logic [HALF_W-1:0] add_s;
    logic              add_c;
    logic              out_valid;
    logic              out_ready;
    logic [FULL_W-1:0] out_sum;
    logic              out_carry;

    modport slave (
        input  in_valid, in_a, in_b, add_s, add_c, out_ready,
        output in_ready, add_a, add_b, out_valid, out_sum, out_carry
    );

    modport master (
        output in_valid, in_a, in_b, add_s, add_c, out_ready,
        input  in_ready, add_a, add_b, out_valid, out_sum, out_carry
    );

endinterface

// File: rtl/add4_seq_ctrl.sv
// rtl/add4_seq_ctrl.sv - builds a 4-bit add with carry-out from one 2-bit slice over 3-4 cycles
module add4_seq_ctrl
    import add4_seq_pkg::*;
#(
    parameter bit HOLD_OPERANDS = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    add4_seq_ctrl_if.slave      bus
);

    state_t            state_q;
    logic [FULL_W-1:0] ra_q;
    logic [FULL_W-1:0] rb_q;
    logic [FULL_W-1:0] sum_q;
    logic              c0_q;
    logic              c1_q;
    logic              c2_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [FULL_W-1:0] out_sum_q;
    logic              out_carry_q;
    logic [HALF_W-1:0] last_a_q;
    logic [HALF_W-1:0] last_b_q;
    logic [HALF_W-1:0] op_a_d;
    logic [HALF_W-1:0] op_b_d;

    // Slice operands decode from registered state only, so the slice sees no input-to-output path.
    always_comb begin
        op_a_d = HOLD_OPERANDS ? last_a_q : '0;
        op_b_d = HOLD_OPERANDS ? last_b_q : '0;
        case (state_q)
            LO: begin
                op_a_d = ra_q[1:0];
                op_b_d = rb_q[1:0];
            end
            HI: begin
                op_a_d = ra_q[3:2];
                op_b_d = rb_q[3:2];
            end
            FIX: begin
                op_a_d = sum_q[3:2];
                op_b_d = FIX_ADDEND;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ra_q        <= '0;
            rb_q        <= '0;
            sum_q       <= '0;
            c0_q        <= 1'b0;
            c1_q        <= 1'b0;
            c2_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_carry_q <= 1'b0;
            last_a_q    <= '0;
            last_b_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        ra_q       <= bus.in_a;
                        rb_q       <= bus.in_b;
                        c0_q       <= 1'b0;
                        c1_q       <= 1'b0;
                        c2_q       <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= LO;
                    end
                end
                LO: begin
                    sum_q[1:0] <= bus.add_s;
                    c0_q       <= bus.add_c;
                    last_a_q   <= op_a_d;
                    last_b_q   <= op_b_d;
                    state_q    <= HI;
                end
                HI: begin
                    sum_q[3:2] <= bus.add_s;
                    c1_q       <= bus.add_c;
                    last_a_q   <= op_a_d;
                    last_b_q   <= op_b_d;
                    if (c0_q) begin
                        state_q <= FIX;
                    end else begin
                        out_sum_q   <= {bus.add_s, sum_q[1:0]};
                        out_carry_q <= bus.add_c;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                FIX: begin
                    // Low-half carry is folded in by adding 1 to the upper half.
                    sum_q[3:2]  <= bus.add_s;
                    c2_q        <= bus.add_c;
                    last_a_q    <= op_a_d;
                    last_b_q    <= op_b_d;
                    out_sum_q   <= {bus.add_s, sum_q[1:0]};
                    out_carry_q <= c1_q | bus.add_c;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_carry = out_carry_q;
    assign bus.add_a     = op_a_d;
    assign bus.add_b     = op_b_d;

endmodule

// File: tb/tb_add4_seq_ctrl.sv
// tb/tb_add4_seq_ctrl.sv - scoreboard bench for add4_seq_ctrl with a 2-bit slice model
module tb_add4_seq_ctrl;
    import add4_seq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    add4_seq_ctrl_if bus ();

    add4_seq_ctrl #(.HOLD_OPERANDS(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 2-bit combinational slice, no carry-in
    assign {bus.add_c, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b};

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [4:0] exp_q[$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_latency(input logic [3:0] a, input logic [3:0] b);
        return ((int'(a[1:0]) + int'(b[1:0])) > 3) ? 4 : 3;
    endfunction

    // Drive a pair at a negedge in IDLE; returns at the negedge right after the accept edge.
    task automatic start_op(input logic [3:0] a, input logic [3:0] b);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        check("in_ready_idle", 8'(bus.in_ready), 8'd1);
        exp_q.push_back({1'b0, a} + {1'b0, b});
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("in_ready_busy", 8'(bus.in_ready), 8'd0);
        check("lo_add_a", 8'(bus.add_a), 8'(a[1:0]));
        check("lo_add_b", 8'(bus.add_b), 8'(b[1:0]));
    endtask

    task automatic wait_result(input logic [3:0] a, input logic [3:0] b);
        int         cnt;
        logic [1:0] hi_sum;
        cnt    = 1;
        hi_sum = a[3:2] + b[3:2];
        while (!bus.out_valid && cnt < 12) begin
            @(negedge clk);
            cnt++;
            if (cnt == 2) begin
                check("hi_add_a", 8'(bus.add_a), 8'(a[3:2]));
                check("hi_add_b", 8'(bus.add_b), 8'(b[3:2]));
            end
            if (cnt == 3 && exp_latency(a, b) == 4) begin
                check("fix_add_a", 8'(bus.add_a), 8'(hi_sum));
                check("fix_add_b", 8'(bus.add_b), 8'd1);
            end
            check("c1_c2_exclusive", 8'(dut.c1_q & dut.c2_q), 8'd0);
        end
        check("latency", 8'(cnt), 8'(exp_latency(a, b)));
        check("out_valid_done", 8'(bus.out_valid), 8'd1);
    endtask

    task automatic finish_op();
        logic [4:0] e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 8'd1, 8'd0);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        check("out_sum", 8'(bus.out_sum), 8'(e[3:0]));
        check("out_carry", 8'(bus.out_carry), 8'(e[4]));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("out_valid_cleared", 8'(bus.out_valid), 8'd0);
        check("in_ready_restored", 8'(bus.in_ready), 8'd1);
        check("out_sum_held", 8'(bus.out_sum), 8'(e[3:0]));
        check("idle_add_a", 8'(bus.add_a), 8'd0);
    endtask

    task automatic do_op(input logic [3:0] a, input logic [3:0] b);
        start_op(a, b);
        wait_result(a, b);
        finish_op();
    endtask

    initial begin
        logic [4:0] e;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 8'(bus.in_ready), 8'd1);
        check("rst_out_valid", 8'(bus.out_valid), 8'd0);
        check("rst_out_sum", 8'(bus.out_sum), 8'd0);
        check("rst_out_carry", 8'(bus.out_carry), 8'd0);
        check("rst_add_a", 8'(bus.add_a), 8'd0);
        check("rst_add_b", 8'(bus.add_b), 8'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 8'(bus.in_ready), 8'd1);

        do_op(4'h5, 4'h2);
        do_op(4'h3, 4'h1);
        do_op(4'hF, 4'h1);
        do_op(4'hC, 4'h8);

        // Backpressure: DONE must hold while out_ready stays low
        start_op(4'h9, 4'h6);
        wait_result(4'h9, 4'h6);
        e = exp_q[0];
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0];
            bus.in_a     = 4'(i + 3);
            @(negedge clk);
            check("bp_out_valid", 8'(bus.out_valid), 8'd1);
            check("bp_in_ready", 8'(bus.in_ready), 8'd0);
            check("bp_out_sum", 8'(bus.out_sum), 8'(e[3:0]));
            check("bp_out_carry", 8'(bus.out_carry), 8'(e[4]));
        end
        e = exp_q.pop_front();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a      = 4'h2;
        bus.in_b      = 4'h3;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bubble_out_valid", 8'(bus.out_valid), 8'd0);
        check("bubble_in_ready", 8'(bus.in_ready), 8'd1);
        check("bubble_out_sum", 8'(bus.out_sum), 8'(e[3:0]));
        start_op(4'h2, 4'h3);
        wait_result(4'h2, 4'h3);
        finish_op();

        // Reset during HI discards the partial result
        start_op(4'hF, 4'hF);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 8'(bus.out_valid), 8'd0);
        check("midrst_in_ready", 8'(bus.in_ready), 8'd1);
        check("midrst_out_sum", 8'(bus.out_sum), 8'd0);
        check("midrst_out_carry", 8'(bus.out_carry), 8'd0);
        check("midrst_add_a", 8'(bus.add_a), 8'd0);
        check("midrst_add_b", 8'(bus.add_b), 8'd0);
        void'(exp_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("postrst_no_valid", 8'(bus.out_valid), 8'd0);
        end
        check("postrst_in_ready", 8'(bus.in_ready), 8'd1);

        for (int i = 0; i < 256; i++) begin
            logic [7:0] p;
            p = 8'(i);
            do_op(p[7:4], p[3:0]);
        end

        check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
